// File: rtl/binary_game_ctrl.sv
// Round sequencer for the binary-guessing game: LFSR targets, per-round countdown, score and miss tracking.
// Pulses register one cycle after their cause; no backpressure, btn_start is dropped outside IDLE/OVER.
module binary_game_ctrl #(
    parameter int          TICKS_PER_SEC = 100000000,
    parameter int          ROUND_SECS    = 10,
    parameter int          HOLD_CYCLES   = 4,
    parameter int          MAX_MISSES    = 3,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       is_equal,
    output logic [7:0] number,
    output logic [3:0] time_left,
    output logic [7:0] score,
    output logic [1:0] misses,
    output logic [1:0] state,
    output logic       round_win,
    output logic       round_lose,
    output logic       game_over
);

    localparam int TW = $clog2(TICKS_PER_SEC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_PLAY = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t        cur_st;
    state_t        nxt_st;
    logic [7:0]    lfsr;
    logic [7:0]    lfsr_nxt;
    logic [7:0]    hold;
    logic [TW-1:0] tick;
    logic          arm_cnt;

    logic start_req;
    logic win;
    logic wrap;
    logic timeout;
    logic last_miss;
    logic load;
    logic arm_done;

    assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_st <= S_IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    // Win outranks a timeout landing on the same tick wrap.
    always_comb begin
        start_req = btn_start && ((cur_st == S_IDLE) || (cur_st == S_OVER));
        win       = (cur_st == S_PLAY) && is_equal && (hold == 8'(HOLD_CYCLES - 1));
        wrap      = (cur_st == S_PLAY) && (tick == TW'(TICKS_PER_SEC - 1));
        timeout   = wrap && (time_left == 4'd1) && !win;
        last_miss = ((misses + 2'd1) == 2'(MAX_MISSES));
        load      = start_req || win || (timeout && !last_miss);
        arm_done  = (cur_st == S_ARM) && arm_cnt;
        nxt_st    = cur_st;
        case (cur_st)
            S_IDLE:  if (start_req) nxt_st = S_ARM;
            S_ARM:   if (arm_done)  nxt_st = S_PLAY;
            S_PLAY: begin
                if (win)          nxt_st = S_ARM;
                else if (timeout) nxt_st = last_miss ? S_OVER : S_ARM;
            end
            default: if (start_req) nxt_st = S_ARM;
        endcase
    end

    always_comb begin
        state     = cur_st;
        game_over = (cur_st == S_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr       <= LFSR_SEED;
            number     <= 8'd0;
            time_left  <= 4'd0;
            score      <= 8'd0;
            misses     <= 2'd0;
            hold       <= 8'd0;
            tick       <= '0;
            arm_cnt    <= 1'b0;
            round_win  <= 1'b0;
            round_lose <= 1'b0;
        end else begin
            round_win  <= win;
            round_lose <= timeout;
            arm_cnt    <= (cur_st == S_ARM) ? ~arm_cnt : 1'b0;
            hold       <= ((cur_st == S_PLAY) && is_equal && !win) ? hold + 8'd1 : 8'd0;

            if (load) begin
                number <= lfsr;
                lfsr   <= lfsr_nxt;
            end

            if (start_req) begin
                score  <= 8'd0;
                misses <= 2'd0;
            end else if (win) begin
                score <= (score == 8'hFF) ? score : score + 8'd1;
            end else if (timeout) begin
                misses <= misses + 2'd1;
            end

            // A timeout is simply the wrap that takes time_left from 1 to 0.
            if (arm_done) begin
                time_left <= 4'(ROUND_SECS);
                tick      <= '0;
            end else if ((cur_st == S_PLAY) && !win) begin
                if (wrap) begin
                    tick      <= '0;
                    time_left <= time_left - 4'd1;
                end else begin
                    tick <= tick + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_binary_game_ctrl.sv
// Scoreboard bench for binary_game_ctrl with a registered sw==number comparator model.
module tb_binary_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_start;
    logic       is_equal;
    logic [7:0] sw;
    logic [7:0] number;
    logic [3:0] time_left;
    logic [7:0] score;
    logic [1:0] misses;
    logic [1:0] state;
    logic       round_win;
    logic       round_lose;
    logic       game_over;

    always #5 clk = ~clk;

    binary_game_ctrl #(
        .TICKS_PER_SEC(10),
        .ROUND_SECS   (3),
        .HOLD_CYCLES  (4),
        .MAX_MISSES   (3),
        .LFSR_SEED    (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_start (btn_start),
        .is_equal  (is_equal),
        .number    (number),
        .time_left (time_left),
        .score     (score),
        .misses    (misses),
        .state     (state),
        .round_win (round_win),
        .round_lose(round_lose),
        .game_over (game_over)
    );

    always @(posedge clk) is_equal <= (sw == number);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit         win;
        logic [7:0] score;
        logic [1:0] misses;
        logic [7:0] number;
        logic [1:0] st;
    } ev_t;

    ev_t exp_q[$];

    logic [7:0] m_lfsr;
    logic [7:0] m_num;
    logic [7:0] m_score;
    logic [1:0] m_miss;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic model_load();
        m_num  = m_lfsr;
        m_lfsr = lfsr_step(m_lfsr);
    endtask

    task automatic push_ev(input bit win, input logic [1:0] st);
        ev_t e;
        e.win    = win;
        e.score  = m_score;
        e.misses = m_miss;
        e.number = m_num;
        e.st     = st;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin : mon
        ev_t e;
        if (rst_n === 1'b1 && (round_win || round_lose)) begin
            chk("pulse_both", 32'(round_win & round_lose), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexp_pulse", 32'({round_win, round_lose}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ev_win",    32'(round_win),  32'(e.win));
                chk("ev_lose",   32'(round_lose), 32'(!e.win));
                chk("ev_score",  32'(score),      32'(e.score));
                chk("ev_misses", 32'(misses),     32'(e.misses));
                chk("ev_number", 32'(number),     32'(e.number));
                chk("ev_state",  32'(state),      32'(e.st));
            end
        end
    end

    task automatic start_game();
        btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
        model_load();
        m_score = 8'd0;
        m_miss  = 2'd0;
    endtask

    task automatic wait_play();
        int n = 0;
        while (state != 2'd2 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("play_enter", 32'(state), 32'd2);
    endtask

    task automatic wait_pulse(input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(round_win || round_lose) && n < maxc);
        if (!(round_win || round_lose)) chk("pulse_wait", 32'd0, 32'd1);
    endtask

    task automatic run_timeout(input bit last);
        sw = ~m_num;
        wait_play();
        for (int k = 1; k <= 30; k++) begin
            if (k % 10 == 0 || k % 10 == 1) chk("tl_step", 32'(time_left), 32'(3 - (k - 1) / 10));
            if (k == 30) begin
                m_miss = m_miss + 2'd1;
                if (!last) model_load();
                push_ev(1'b0, last ? 2'd3 : 2'd1);
            end
            @(negedge clk);
        end
        chk("to_pulse", 32'(round_lose), 32'd1);
        chk("to_tl0",   32'(time_left),  32'd0);
        chk("to_state", 32'(state),      last ? 32'd3 : 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired after checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rise;
        rst_n     = 1'b0;
        btn_start = 1'b0;
        sw        = 8'h00;
        m_lfsr    = 8'hA5;
        m_num     = 8'h00;
        m_score   = 8'd0;
        m_miss    = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_state",  32'(state),      32'd0);
        chk("rst_number", 32'(number),     32'd0);
        chk("rst_tl",     32'(time_left),  32'd0);
        chk("rst_score",  32'(score),      32'd0);
        chk("rst_misses", 32'(misses),     32'd0);
        chk("rst_gover",  32'(game_over),  32'd0);
        chk("rst_win",    32'(round_win),  32'd0);
        chk("rst_lose",   32'(round_lose), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // First round start and two-cycle arm window
        start_game();
        chk("t1_num",  32'(number), 32'hA5);
        chk("t1_arm1", 32'(state),  32'd1);
        @(negedge clk);
        chk("t1_arm2", 32'(state),  32'd1);
        @(negedge clk);
        chk("t1_play",   32'(state),     32'd2);
        chk("t1_tl",     32'(time_left), 32'd3);
        chk("t1_score",  32'(score),     32'd0);
        chk("t1_misses", 32'(misses),    32'd0);

        // Steady match wins after four is_equal cycles
        sw = 8'hA5;
        m_score = 8'd1;
        model_load();
        push_ev(1'b1, 2'd1);
        rise = -1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (is_equal && rise < 0) rise = n;
            if (round_win || round_lose) break;
        end
        chk("t2_lat",   32'(n - rise), 32'd4);
        chk("t2_num",   32'(number),   32'h4A);
        chk("t2_state", 32'(state),    32'd1);

        // Three matches, one gap, then four fresh matches
        sw = ~m_num;
        wait_play();
        sw = m_num;
        repeat (3) @(negedge clk);
        sw = ~m_num;
        @(negedge clk);
        chk("t3_gap", 32'(is_equal), 32'd0);
        m_score = 8'd2;
        model_load();
        push_ev(1'b1, 2'd1);
        sw = number;
        wait_pulse(12, n);
        chk("t3_lat", 32'(n), 32'd5);

        // Timeouts until game over
        run_timeout(1'b0);
        run_timeout(1'b0);
        run_timeout(1'b1);
        chk("t5_gover", 32'(game_over), 32'd1);
        repeat (5) @(negedge clk);
        chk("t5_hold_num",   32'(number), 32'(m_num));
        chk("t5_hold_score", 32'(score),  32'd2);
        chk("t5_hold_miss",  32'(misses), 32'd3);
        chk("t5_hold_state", 32'(state),  32'd3);

        start_game();
        chk("t5_rs_state", 32'(state),     32'd1);
        chk("t5_rs_gover", 32'(game_over), 32'd0);
        chk("t5_rs_num",   32'(number),    32'(m_num));
        chk("t5_rs_score", 32'(score),     32'd0);
        chk("t5_rs_miss",  32'(misses),    32'd0);

        // Fourth match lands on the final tick: win only
        sw = ~m_num;
        wait_play();
        for (int k = 1; k <= 30; k++) begin
            if (k == 26) sw = m_num;
            if (k == 30) begin
                chk("t5_tl_last", 32'(time_left), 32'd1);
                m_score = 8'd1;
                model_load();
                push_ev(1'b1, 2'd1);
            end
            @(negedge clk);
        end
        chk("t5_cwin",  32'(round_win),  32'd1);
        chk("t5_clos",  32'(round_lose), 32'd0);
        chk("t5_cmiss", 32'(misses),     32'd0);

        // Score to two, then reset mid-play
        wait_play();
        sw = m_num;
        m_score = 8'd2;
        model_load();
        push_ev(1'b1, 2'd1);
        wait_pulse(12, n);
        sw = ~m_num;
        wait_play();
        repeat (3) @(negedge clk);
        chk("t6_pre_score", 32'(score), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_state",  32'(state),      32'd0);
        chk("t6_number", 32'(number),     32'd0);
        chk("t6_tl",     32'(time_left),  32'd0);
        chk("t6_score",  32'(score),      32'd0);
        chk("t6_misses", 32'(misses),     32'd0);
        chk("t6_gover",  32'(game_over),  32'd0);
        chk("t6_win",    32'(round_win),  32'd0);
        chk("t6_lose",   32'(round_lose), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        m_lfsr = 8'hA5;
        @(negedge clk);
        start_game();
        chk("t6_num", 32'(number), 32'hA5);
        chk("q_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
